// File: rtl/serial_adder_pkg.sv
// Shared types for serial_adder: state enum built on the shared encodings.
`include "serial_adder_defs.vh"

package serial_adder_pkg;
    typedef enum logic [1:0] {
        S_IDLE = `IDLE,
        S_RUN  = `RUN,
        S_DONE = `DONE
    } state_t;
endpackage

// File: rtl/serial_adder_defs.vh
// State encodings shared by serial_adder and anything that decodes its state.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define IDLE 2'd0
`define RUN  2'd1
`define DONE 2'd2
`endif

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell; port order is carry, sum, a, b, c_in.
module fa (
    output logic carry,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, one fa cell plus a carry flop.
// Optional signed overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t        state;
    logic [W-1:0]  ra, rb;
    logic          cy;
    logic [CW-1:0] cnt;
    logic          fa_s, fa_c;

    fa u_fa (fa_c, fa_s, ra[0], rb[0], cy);

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB; overflow is its disagreement with the carry out.
    logic cmsb;
    assign ovf = cmsb ^ c_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ra    <= '0;
            rb    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        ra    <= a;
                        rb    <= b;
                        cy    <= c_in;
                        cnt   <= '0;
                        sum   <= '0;
                        c_out <= 1'b0;
                        busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        cmsb  <= 1'b0;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    sum <= {fa_s, sum[W-1:1]};
                    cy  <= fa_c;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        cmsb  <= cy;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (W=8): driver pushes expected results, monitor checks on done.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, c_in;
    logic [W-1:0] a, b;
    logic         busy, done, c_out;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busycnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the oldest expected result whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("busy_and_done", {63'd0, busy & done}, 64'd0);
            if (done) begin
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=sum %0h required=no result", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", {56'd0, sum}, {56'd0, e.s});
                    chk("c_out", {63'd0, c_out}, {63'd0, e.co});
                    chk("latency", 64'(cyc - e.acc), 64'(W));
                    chk("busy_cycles", 64'(busycnt), 64'(W));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
                end
                busycnt = 0;
            end else if (busy) begin
                busycnt++;
            end else begin
                busycnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.s = s; e.co = co; e.ov = ov; e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic go(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                      input logic [W-1:0] s, input logic co, input logic ov);
        @(negedge clk);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        @(posedge clk); #1;
        push_exp(s, co, ov);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            failures++;
            $display("FAIL done_timeout actual=no done required=done within 100 cycles");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {56'd0, sum}, 64'd0);
        chk("rst_c_out", {63'd0, c_out}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif

        go(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done();
        go(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_done();
        // Result must hold while idle.
        repeat (3) @(negedge clk);
        chk("hold_sum", {56'd0, sum}, 64'h00);
        chk("hold_c_out", {63'd0, c_out}, 64'd1);
        chk("hold_busy", {63'd0, busy}, 64'd0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        a = 8'h55; b = 8'hAA; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        push_exp(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h03; b = 8'h04; c_in = 1'b0;
        wait_done();
        @(posedge clk); #1;
        push_exp(8'h07, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // start during RUN must be ignored.
        go(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-RUN discards the partial result.
        go(8'h99, 8'h11, 1'b0, 8'hAA, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_sum", {56'd0, sum}, 64'd0);
        chk("midrst_c_out", {63'd0, c_out}, 64'd0);
        go(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        wait_done();

        go(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_done();
        go(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        wait_done();
        go(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end
endmodule
